// File: rtl/wallace_mult_pipe.sv
// Two-stage pipelined Wallace-tree multiplier with valid/ready flow control.
// Define WALLACE_MULT_SIGNED_EN to add per-op Baugh-Wooley signed mode.
module wallace_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef WALLACE_MULT_SIGNED_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product
);

  localparam int PW = 2 * WIDTH;

  typedef logic [PW-1:0] row_t;

  row_t pp [WIDTH];
  row_t lv [WIDTH];
  row_t nx [WIDTH];
  int   n_rows;
  int   m_rows;
  row_t cs_sum;
  row_t cs_carry;

  row_t s1_sum;
  row_t s1_carry;
  logic s1_valid;
  logic s2_load;
  logic accept;
  row_t cpa;

  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~flush & (~s1_valid | s2_load);
  assign accept   = in_valid & in_ready;

  // Partial products; signed mode inverts the bits touching exactly one sign bit
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        logic bit_v;
        bit_v = in_a[j] & in_b[i];
`ifdef WALLACE_MULT_SIGNED_EN
        if (in_signed && ((i == WIDTH-1) != (j == WIDTH-1)))
          bit_v = ~bit_v;
`endif
        pp[i][i+j] = bit_v;
      end
    end
  end

  // Wallace levels: each group of three rows becomes a sum row and a carry row
  always_comb begin
    lv     = pp;
    nx     = '{default: '0};
    n_rows = WIDTH;
    m_rows = 0;
    for (int l = 0; l < WIDTH; l++) begin
      nx     = '{default: '0};
      m_rows = 0;
      for (int g = 0; g < WIDTH / 3; g++) begin
        if (3*g + 2 < n_rows) begin
          nx[m_rows]   = lv[3*g] ^ lv[3*g+1] ^ lv[3*g+2];
          nx[m_rows+1] = ((lv[3*g] & lv[3*g+1]) |
                          (lv[3*g] & lv[3*g+2]) |
                          (lv[3*g+1] & lv[3*g+2])) << 1;
          m_rows       = m_rows + 2;
        end
      end
      for (int k = 0; k < WIDTH; k++) begin
        if (k >= 3*(n_rows/3) && k < n_rows) begin
          nx[m_rows] = lv[k];
          m_rows     = m_rows + 1;
        end
      end
      if (n_rows > 2) begin
        lv     = nx;
        n_rows = m_rows;
      end
    end
    cs_sum   = lv[0];
    cs_carry = (n_rows > 1) ? lv[1] : '0;
  end

`ifdef WALLACE_MULT_SIGNED_EN
  localparam row_t CORR = (row_t'(1) << WIDTH) | (row_t'(1) << (PW-1));
  logic s1_signed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      s1_signed <= 1'b0;
    else if (accept)
      s1_signed <= in_signed;
  end

  assign cpa = s1_sum + s1_carry + (s1_signed ? CORR : '0);
`else
  assign cpa = s1_sum + s1_carry;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_sum      <= '0;
      s1_carry    <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_sum   <= cs_sum;
        s1_carry <= cs_carry;
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        out_product <= cpa;
        out_valid   <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Scoreboard bench for wallace_mult_pipe: WIDTH=8 directed ops plus
// an exhaustive WIDTH=5 sweep on a second instance.
module tb_wallace_mult_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_product;
`ifdef WALLACE_MULT_SIGNED_EN
  logic        in_signed = 1'b0;
`endif

  logic        v5 = 1'b0;
  logic        ir5;
  logic [4:0]  a5 = '0;
  logic [4:0]  b5 = '0;
  logic        ov5;
  logic [9:0]  p5;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [15:0] q8 [$];
  logic [9:0]  q5 [$];
  int pop_cyc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wallace_mult_pipe #(.WIDTH(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
`ifdef WALLACE_MULT_SIGNED_EN
    .in_signed(in_signed),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product)
  );

  wallace_mult_pipe #(.WIDTH(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .flush(1'b0),
    .in_valid(v5), .in_ready(ir5),
    .in_a(a5), .in_b(b5),
`ifdef WALLACE_MULT_SIGNED_EN
    .in_signed(1'b0),
`endif
    .out_valid(ov5), .out_ready(1'b1),
    .out_product(p5)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic s);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    if (s) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return sa * sb;
    end
    return {8'd0, a} * {8'd0, b};
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic s, input bit strict);
    int  tries;
    bit  done;
    tries = 0;
    done  = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
`ifdef WALLACE_MULT_SIGNED_EN
    in_signed = s;
`endif
    while (!done) begin
      #4;
      if (in_ready) begin
        q8.push_back(model8(a, b, s));
        acc_cyc = cyc;
        done = 1;
      end else begin
        if (strict) chk("in_ready_stall", 0, 1);
        tries++;
        if (tries > 50) begin
          chk("send_timeout", 0, 1);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    #4;
    if (out_valid && out_ready) begin
      if (q8.size() == 0) chk("spurious8", 1, 0);
      else chk("prod8", {16'd0, out_product}, {16'd0, q8.pop_front()});
      pop_cyc.push_back(cyc);
    end
  end

  initial forever begin
    @(negedge clk);
    #4;
    if (ov5) begin
      if (q5.size() == 0) chk("spurious5", 1, 0);
      else chk("prod5", {22'd0, p5}, {22'd0, q5.pop_front()});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_ov", {31'd0, out_valid}, 0);
    chk("rst_prod", {16'd0, out_product}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #4;
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    // single op latency
    pop_cyc.delete();
    send(8'd255, 8'd255, 1'b0, 1'b1);
    idle();
    repeat (4) @(negedge clk);
    chk("one_out", pop_cyc.size(), 1);
    if (pop_cyc.size() > 0) chk("latency", pop_cyc[0] - acc_cyc, 2);
    #4;
    chk("ov_after", {31'd0, out_valid}, 0);

    // back-to-back
    pop_cyc.delete();
    send(8'd3, 8'd5, 1'b0, 1'b1);
    send(8'd0, 8'd200, 1'b0, 1'b1);
    send(8'd1, 8'd255, 1'b0, 1'b1);
    send(8'd128, 8'd2, 1'b0, 1'b1);
    idle();
    repeat (4) @(negedge clk);
    chk("b2b_cnt", pop_cyc.size(), 4);
    for (int i = 0; i + 1 < pop_cyc.size(); i++)
      chk("b2b_gap", pop_cyc[i+1] - pop_cyc[i], 1);

    // backpressure
    pop_cyc.delete();
    out_ready = 1'b0;
    send(8'd10, 8'd11, 1'b0, 1'b1);
    send(8'd12, 8'd13, 1'b0, 1'b1);
    @(negedge clk);
    in_a = 8'd14;
    in_b = 8'd15;
    #4;
    chk("bp_ready", {31'd0, in_ready}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #4;
      chk("bp_hold_v", {31'd0, out_valid}, 1);
      chk("bp_hold_p", {16'd0, out_product}, 110);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(8'd14, 8'd15, 1'b0, 1'b0);
    idle();
    repeat (5) @(negedge clk);
    chk("bp_cnt", pop_cyc.size(), 3);
    chk("bp_q", q8.size(), 0);

    // reset with both stages full
    out_ready = 1'b0;
    send(8'd7, 8'd9, 1'b0, 1'b1);
    send(8'd11, 8'd13, 1'b0, 1'b1);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ov", {31'd0, out_valid}, 0);
    chk("arst_prod", {16'd0, out_product}, 0);
    q8.delete();
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    #4;
    chk("arst_ready", {31'd0, in_ready}, 1);
    repeat (3) @(negedge clk);
    #4;
    chk("arst_stale", {31'd0, out_valid}, 0);

    // flush with both stages full
    out_ready = 1'b0;
    send(8'd6, 8'd7, 1'b0, 1'b1);
    send(8'd8, 8'd9, 1'b0, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    in_a = 8'd3;
    in_b = 8'd3;
    #4;
    chk("fl_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #4;
    chk("fl_ov", {31'd0, out_valid}, 0);
    chk("fl_prod", {16'd0, out_product}, 42);
    q8.delete();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    chk("fl_s1", {31'd0, out_valid}, 0);

`ifdef WALLACE_MULT_SIGNED_EN
    send(8'h80, 8'hFF, 1'b1, 1'b1);
    send(8'h80, 8'h7F, 1'b1, 1'b1);
    send(8'h80, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    idle();
`endif

    // random unsigned stream
    for (int i = 0; i < 40; i++)
      send(8'($urandom), 8'($urandom), 1'b0, 1'b1);
    idle();

    // exhaustive WIDTH=5
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        @(negedge clk);
        v5 = 1'b1;
        a5 = 5'(a);
        b5 = 5'(b);
        #4;
        if (ir5) q5.push_back(10'(a * b));
        else chk("w5_ready", 0, 1);
      end
    end
    @(negedge clk);
    v5 = 1'b0;

    repeat (6) @(negedge clk);
    chk("drain8", q8.size(), 0);
    chk("drain5", q5.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
